// File: rtl/nibble_serial_addsub.sv
// Nibble-serial two's-complement add/sub: one 4-bit slice per clock, ripple
// carry held in a register, V/N/Z flags and optional saturation on overflow.

// 4-bit add slice with carry in/out; subtraction is handled by the caller
// feeding ~b and carry-in = 1.
module nibble_addsub_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module nibble_serial_addsub #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_z,
  output logic             busy
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;       // already inverted for subtract
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              flag_v_q, flag_v_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;

  logic [3:0]        nib_s;
  logic              nib_c;
  logic              raw_v;
  logic [WIDTH-1:0]  final_res;

  // Single shared slice; the operand nibbles are selected by idx.
  nibble_addsub_slice u_slice (
    .a    (a_q[{idx_q, 2'b00} +: 4]),
    .b    (b_q[{idx_q, 2'b00} +: 4]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    flag_v_d  = flag_v_q;
    flag_n_d  = flag_n_q;
    flag_z_d  = flag_z_q;
    raw_v     = 1'b0;
    final_res = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;            // +1 completes the two's-complement negate
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = nib_s;
        carry_d = nib_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDXW'(NIB - 1)) begin
          // Top nibble: carry out is dropped, overflow judged on sign bits.
          raw_v     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
          final_res = result_d;
          if (SATURATE != 0 && raw_v)
            final_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
          result_d  = final_res;
          flag_v_d  = raw_v;
          flag_n_d  = final_res[WIDTH-1];
          flag_z_d  = (final_res == '0);
          idx_d     = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      flag_v_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      flag_v_q <= flag_v_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign flag_v    = flag_v_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: saturating and wrapping instances share
// stimulus; a reference model pushes expected results on accept.
module tb_nibble_serial_addsub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;

  logic        in_ready_s, out_valid_s, fv_s, fn_s, fz_s, busy_s;
  logic        in_ready_w, out_valid_w, fv_w, fn_w, fz_w, busy_w;
  logic [15:0] result_s, result_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] rs;
    logic [15:0] rw;
    logic        v;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  nibble_serial_addsub #(.WIDTH(16), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .flag_v(fv_s), .flag_n(fn_s), .flag_z(fz_s), .busy(busy_s));

  nibble_serial_addsub #(.WIDTH(16), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_w), .out_ready(out_ready),
    .result(result_w), .flag_v(fv_w), .flag_n(fn_w), .flag_z(fz_w), .busy(busy_w));

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
    exp_t e;
    logic [15:0] bop, raw;
    bop  = ts ? ~tb_ : tb_;
    raw  = ta + bop + {15'b0, ts};
    e.v  = (ta[15] == bop[15]) && (raw[15] != ta[15]);
    e.rw = raw;
    e.rs = e.v ? (ta[15] ? 16'h8000 : 16'h7FFF) : raw;
    return e;
  endfunction

  // Present one op, push its expectation on accept, wait (bounded) for out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                        output int lat, output bit ir_seen);
    int w = 0;
    in_valid = 1'b1; a = ta; b = tb_; sub = ts;
    while (!in_ready_s && w < 20) begin @(posedge clk); #1; w++; end
    q.push_back(model(ta, tb_, ts));
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 0; ir_seen = 1'b0;
    while (!out_valid_s && lat < 20) begin
      if (in_ready_s || in_ready_w) ir_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({result_s, fv_s, fn_s, fz_s, out_valid_s, busy_s, in_ready_s} !== {16'h0, 5'b00001} ||
        {result_w, fv_w, fn_w, fz_w, out_valid_w, busy_w, in_ready_w} !== {16'h0, 5'b00001}) begin
      errors++;
      $display("FAIL reset_state: sat=%h/%b%b%b ov=%b busy=%b rdy=%b wrap=%h want 0000 flags 0 ov=0 busy=0 rdy=1",
               result_s, fv_s, fn_s, fz_s, out_valid_s, busy_s, in_ready_s, result_w);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [32:0] tbl [5];
    tbl[0] = {16'h7FFF, 16'h0001, 1'b0};
    tbl[1] = {16'h8000, 16'h0001, 1'b1};
    tbl[2] = {16'h0005, 16'h0005, 1'b1};
    tbl[3] = {16'h8000, 16'h8000, 1'b0};
    tbl[4] = {16'h1234, 16'h0234, 1'b1};
    for (int i = 0; i < 5; i++) begin
      int lat; bit irs; exp_t e;
      run_op(tbl[i][32:17], tbl[i][16:1], tbl[i][0], lat, irs);
      e = q.pop_front();
      checks++;
      if (lat != 4) begin errors++; $display("FAIL vec%0d_latency: got %0d want 4", i, lat); end
      checks++;
      if ({out_valid_s, result_s, fv_s, fn_s, fz_s} !== {1'b1, e.rs, e.v, e.rs[15], e.rs == 16'h0}) begin
        errors++;
        $display("FAIL vec%0d_sat: got ov=%b %h v%b n%b z%b want %h v%b n%b z%b", i, out_valid_s,
                 result_s, fv_s, fn_s, fz_s, e.rs, e.v, e.rs[15], e.rs == 16'h0);
      end
      checks++;
      if ({out_valid_w, result_w, fv_w, fn_w, fz_w} !== {1'b1, e.rw, e.v, e.rw[15], e.rw == 16'h0}) begin
        errors++;
        $display("FAIL vec%0d_wrap: got ov=%b %h v%b n%b z%b want %h v%b n%b z%b", i, out_valid_w,
                 result_w, fv_w, fn_w, fz_w, e.rw, e.v, e.rw[15], e.rw == 16'h0);
      end
      handshake();
    end
  endtask

  task automatic test_ripple();
    int lat; bit irs; exp_t e;
    run_op(16'h0FFF, 16'h0001, 1'b0, lat, irs);
    e = q.pop_front();
    checks++;
    if (lat != 4 || irs) begin
      errors++; $display("FAIL ripple_timing: latency %0d in_ready_seen %b want 4 0", lat, irs);
    end
    checks++;
    if ({result_s, fv_s, result_w} !== {16'h1000, 1'b0, 16'h1000} || e.rs !== 16'h1000) begin
      errors++; $display("FAIL ripple_result: got %h v%b wrap %h want 1000 v0", result_s, fv_s, result_w);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat; bit irs; exp_t e;
    run_op(16'h4000, 16'h4000, 1'b0, lat, irs);
    e = q.pop_front();
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid_s, in_ready_s, result_s, fv_s, fn_s, fz_s} !== {2'b10, e.rs, e.v, e.rs[15], e.rs == 16'h0}) begin
        errors++;
        $display("FAIL backpressure_hold%0d: ov=%b rdy=%b %h v%b n%b z%b want ov=1 rdy=0 %h v%b",
                 i, out_valid_s, in_ready_s, result_s, fv_s, fn_s, fz_s, e.rs, e.v);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid_s, busy_s, in_ready_s, result_s} !== {3'b001, e.rs}) begin
      errors++;
      $display("FAIL backpressure_release: ov=%b busy=%b rdy=%b %h want 0 0 1 %h",
               out_valid_s, busy_s, in_ready_s, result_s, e.rs);
    end
    run_op(16'h0001, 16'h0002, 1'b0, lat, irs);
    e = q.pop_front();
    checks++;
    if (lat != 4 || result_s !== 16'h0003 || e.rs !== 16'h0003) begin
      errors++; $display("FAIL backpressure_next: latency %0d result %h want 4 0003", lat, result_s);
    end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int lat; bit irs; exp_t e;
    in_valid = 1'b1; a = 16'h7777; b = 16'h1111; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_s, busy_s, in_ready_s, result_s, fv_s, fn_s, fz_s} !== {3'b001, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid_run: ov=%b busy=%b rdy=%b %h want 0 0 1 0000", out_valid_s, busy_s, in_ready_s, result_s);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h1234, 16'h1111, 1'b0, lat, irs);
    e = q.pop_front();
    checks++;
    if (lat != 4 || result_s !== 16'h2345 || result_w !== e.rw) begin
      errors++; $display("FAIL post_reset_op: latency %0d result %h want 4 2345", lat, result_s);
    end
    handshake();
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int lat; bit irs; exp_t e;
      run_op(16'($urandom), 16'($urandom), 1'($urandom), lat, irs);
      if (q.size() == 0) begin
        checks++; errors++; $display("FAIL rand%0d_scoreboard: queue empty", i);
      end else begin
        e = q.pop_front();
        checks++;
        if (lat != 4 || {result_s, fv_s, fn_s, fz_s} !== {e.rs, e.v, e.rs[15], e.rs == 16'h0} ||
            {result_w, fv_w, fn_w, fz_w} !== {e.rw, e.v, e.rw[15], e.rw == 16'h0}) begin
          errors++;
          $display("FAIL rand%0d: lat %0d sat %h v%b n%b z%b wrap %h want sat %h wrap %h v%b",
                   i, lat, result_s, fv_s, fn_s, fz_s, result_w, e.rs, e.rw, e.v);
        end
      end
      handshake();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_ripple();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
